// File: rtl/hbm_dma_write_arbiter_if.sv
// Requester-side and DMA-side write cmd/data channels of hbm_dma_write_arbiter.
// master = arbiter view, slave = requester/DMA environment view.
interface hbm_dma_write_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]     s_cmd_valid;
   logic [NUM_REQ-1:0]     s_cmd_ready;
   logic [NUM_REQ*64-1:0]  s_cmd_address;
   logic [NUM_REQ*32-1:0]  s_cmd_length;
   logic [NUM_REQ-1:0]     s_data_valid;
   logic [NUM_REQ-1:0]     s_data_ready;
   logic [NUM_REQ*512-1:0] s_data_data;
   logic                   m_cmd_valid;
   logic                   m_cmd_ready;
   logic [63:0]            m_cmd_address;
   logic [31:0]            m_cmd_length;
   logic                   m_data_valid;
   logic                   m_data_ready;
   logic [511:0]           m_data_data;
   logic [63:0]            m_data_keep;
   logic                   m_data_last;

   modport master (
      input  s_cmd_valid, s_cmd_address, s_cmd_length, s_data_valid, s_data_data,
             m_cmd_ready, m_data_ready,
      output s_cmd_ready, s_data_ready, m_cmd_valid, m_cmd_address, m_cmd_length,
             m_data_valid, m_data_data, m_data_keep, m_data_last
   );

   modport slave (
      output s_cmd_valid, s_cmd_address, s_cmd_length, s_data_valid, s_data_data,
             m_cmd_ready, m_data_ready,
      input  s_cmd_ready, s_data_ready, m_cmd_valid, m_cmd_address, m_cmd_length,
             m_data_valid, m_data_data, m_data_keep, m_data_last
   );
endinterface

// File: rtl/hbm_dma_write_arbiter.sv
// Round-robin arbiter sharing one DMA write cmd/data channel among NUM_REQ HBM send-back engines.
// Optional statistics counters: define HBM_DMA_WR_ARB_STATS_EN.
module hbm_dma_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    hbm_clk,
   input  logic                    hbm_areset,
   hbm_dma_write_arbiter_if.master bus,
   output logic [ID_W-1:0]         grant_id,
   output logic                    busy
`ifdef HBM_DMA_WR_ARB_STATS_EN
   ,
   output logic [31:0]             stat_cmd_cnt,
   output logic [31:0]             stat_beat_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] req_sel;
   logic [ID_W-1:0] scan_id;
   logic            req_found;
   logic [26:0]     beats_left;
   logic [26:0]     beats_new;
   logic [63:0]     cmd_address;
   logic [31:0]     cmd_length;
   logic [31:0]     sel_length;
   logic            grant_fire;
   logic            cmd_fire;
   logic            data_fire;

   // Search from the requester after the last grant upward, wrapping around.
   always_comb begin
      req_found = 1'b0;
      req_sel   = '0;
      scan_id   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_id = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!req_found && bus.s_cmd_valid[scan_id]) begin
            req_found = 1'b1;
            req_sel   = scan_id;
         end
      end
   end

   assign sel_length = bus.s_cmd_length[32*req_sel +: 32];
   assign beats_new  = 27'(({1'b0, sel_length} + 33'd63) >> 6);
   assign grant_fire = (state == IDLE) && req_found && !hbm_areset;
   assign cmd_fire   = (state == CMD) && bus.m_cmd_ready;
   assign data_fire  = (state == DATA) && bus.s_data_valid[grant_id] && bus.m_data_ready;

   always_comb begin
      state_nxt        = state;
      bus.s_cmd_ready  = '0;
      bus.s_data_ready = '0;
      bus.m_cmd_valid  = 1'b0;
      bus.m_data_valid = 1'b0;
      bus.m_data_last  = 1'b0;
      bus.m_data_data  = '0;
      case (state)
         IDLE: begin
            if (grant_fire) begin
               bus.s_cmd_ready[req_sel] = 1'b1;
               state_nxt                = CMD;
            end
         end
         CMD: begin
            bus.m_cmd_valid = 1'b1;
            if (bus.m_cmd_ready)
               state_nxt = (beats_left == '0) ? IDLE : DATA;
         end
         DATA: begin
            bus.m_data_valid           = bus.s_data_valid[grant_id];
            bus.s_data_ready[grant_id] = bus.m_data_ready;
            bus.m_data_data            = bus.s_data_data[512*grant_id +: 512];
            bus.m_data_last            = (beats_left == 27'd1) && bus.s_data_valid[grant_id];
            if (data_fire && beats_left == 27'd1)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command fields are captured at grant so they stay stable through the CMD wait.
   always_ff @(posedge hbm_clk or posedge hbm_areset) begin
      if (hbm_areset) begin
         state       <= IDLE;
         rr_ptr      <= ID_W'(NUM_REQ - 1);
         grant_id    <= '0;
         beats_left  <= '0;
         cmd_address <= '0;
         cmd_length  <= '0;
      end else begin
         state <= state_nxt;
         if (grant_fire) begin
            grant_id    <= req_sel;
            rr_ptr      <= req_sel;
            cmd_address <= bus.s_cmd_address[64*req_sel +: 64];
            cmd_length  <= sel_length;
            beats_left  <= beats_new;
         end else if (data_fire) begin
            beats_left <= beats_left - 27'd1;
         end
      end
   end

   assign bus.m_cmd_address = cmd_address;
   assign bus.m_cmd_length  = cmd_length;
   assign bus.m_data_keep   = '1;
   assign busy              = (state != IDLE);

`ifdef HBM_DMA_WR_ARB_STATS_EN
   always_ff @(posedge hbm_clk or posedge hbm_areset) begin
      if (hbm_areset) begin
         stat_cmd_cnt  <= '0;
         stat_beat_cnt <= '0;
      end else begin
         if (cmd_fire)
            stat_cmd_cnt <= stat_cmd_cnt + 32'd1;
         if (data_fire)
            stat_beat_cnt <= stat_beat_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hbm_dma_write_arbiter.sv
// Scoreboard bench for hbm_dma_write_arbiter: a round-robin reference model predicts every DMA
// command and beat; a separate monitor compares them as the DUT presents them.
module tb_hbm_dma_write_arbiter;
   localparam int NUM_REQ  = 4;
   localparam int ID_W     = 2;
   localparam int MAX_CMDS = 16;

   typedef struct {
      logic [63:0]     addr;
      logic [31:0]     len;
      logic [ID_W-1:0] id;
   } cmd_exp_t;

   typedef struct {
      logic [511:0] data;
      logic         last;
   } beat_exp_t;

   logic            hbm_clk = 1'b0;
   logic            hbm_areset;
   logic [ID_W-1:0] grant_id;
   logic            busy;
`ifdef HBM_DMA_WR_ARB_STATS_EN
   logic [31:0]     stat_cmd_cnt;
   logic [31:0]     stat_beat_cnt;
`endif

   hbm_dma_write_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   hbm_dma_write_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .hbm_clk       (hbm_clk),
      .hbm_areset    (hbm_areset),
      .bus           (bus),
      .grant_id      (grant_id),
      .busy          (busy)
`ifdef HBM_DMA_WR_ARB_STATS_EN
      ,
      .stat_cmd_cnt  (stat_cmd_cnt),
      .stat_beat_cnt (stat_beat_cnt)
`endif
   );

   always #5 hbm_clk = ~hbm_clk;

   int              compared   = 0;
   int              mismatched = 0;
   cmd_exp_t        exp_cmd_q[$];
   beat_exp_t       exp_beat_q[$];
   logic [ID_W-1:0] act_grant_q[$];

   logic [63:0]     req_addr [NUM_REQ][MAX_CMDS];
   logic [31:0]     req_len  [NUM_REQ][MAX_CMDS];
   int              req_cnt  [NUM_REQ];
   int              req_idx  [NUM_REQ];
   bit              req_asking  [NUM_REQ];
   bit              req_in_data [NUM_REQ];
   int              req_beat  [NUM_REQ];
   int              req_total [NUM_REQ];
   int              req_seq   [NUM_REQ];

   int              model_last;
   int              cmd_rdy_mode, data_rdy_mode, start_prob, data_prob;
   int              cmd_wait, cyc;
   bit              mon_en;

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic failNote(input string name, input string why);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: %s", name, why);
   endtask

   function automatic int beatsOf(input logic [31:0] len);
      return int'((longint'(len) + 63) / 64);
   endfunction

   function automatic logic [511:0] beatData(input int r, input int s, input int b);
      logic [511:0] d;
      logic [31:0]  w;
      for (int k = 0; k < 16; k++) begin
         w = {8'(r), 8'(s), 8'(b), 8'(k)} ^ 32'h5A3C_96E1;
         d[32*k +: 32] = w * 32'h9E37_79B1;
      end
      return d;
   endfunction

   function automatic bit allDone();
      for (int i = 0; i < NUM_REQ; i++)
         if (req_idx[i] < req_cnt[i] || req_asking[i] || req_in_data[i]) return 1'b0;
      return (exp_cmd_q.size() == 0) && (exp_beat_q.size() == 0);
   endfunction

   task automatic clearReqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_cnt[i]     = 0;
         req_idx[i]     = 0;
         req_asking[i]  = 1'b0;
         req_in_data[i] = 1'b0;
         req_beat[i]    = 0;
         req_total[i]   = 0;
         req_seq[i]     = 0;
      end
   endtask

   task automatic loadCmd(input int r, input logic [63:0] a, input logic [31:0] l);
      req_addr[r][req_cnt[r]] = a;
      req_len[r][req_cnt[r]]  = l;
      req_cnt[r]++;
   endtask

   task automatic setModes(input int cm, input int dm, input int sp, input int dp);
      cmd_rdy_mode  = cm;
      data_rdy_mode = dm;
      start_prob    = sp;
      data_prob     = dp;
   endtask

   task automatic idleInputs();
      bus.s_cmd_valid   = '0;
      bus.s_cmd_address = '0;
      bus.s_cmd_length  = '0;
      bus.s_data_valid  = '0;
      bus.s_data_data   = '0;
      bus.m_cmd_ready   = 1'b0;
      bus.m_data_ready  = 1'b0;
      cmd_wait          = 0;
   endtask

   // The reference model: grant = first valid requester after the last one granted.
   task automatic pushExpected(input int g);
      cmd_exp_t  ce;
      beat_exp_t be;
      int        n;
      ce.addr = req_addr[g][req_idx[g]];
      ce.len  = req_len[g][req_idx[g]];
      ce.id   = ID_W'(g);
      exp_cmd_q.push_back(ce);
      n = beatsOf(ce.len);
      for (int b = 0; b < n; b++) begin
         be.data = beatData(g, req_idx[g], b);
         be.last = (b == n - 1);
         exp_beat_q.push_back(be);
      end
   endtask

   // One clock: observe handshakes at the falling edge, then drive new inputs after the rise.
   task automatic applyStimulus();
      logic [NUM_REQ-1:0] vld, acc, in_mask;
      int g;
      @(negedge hbm_clk);
      vld = bus.s_cmd_valid;
      acc = bus.s_data_valid & bus.s_data_ready;
      in_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) in_mask[i] = req_in_data[i];
      checkOutput("stray_data_ready", 512'(bus.s_data_ready & ~in_mask), 512'(0));
      if (|bus.s_cmd_ready) begin
         if (vld == '0) begin
            failNote("cmd_ready_no_valid", $sformatf("s_cmd_ready=%b while no s_cmd_valid", bus.s_cmd_ready));
         end else begin
            g = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
               int c = (model_last + k) % NUM_REQ;
               if (g < 0 && vld[c]) g = c;
            end
            checkOutput("cmd_ready_grant", 512'(bus.s_cmd_ready), 512'(1) << g);
            model_last = g;
            pushExpected(g);
            for (int h = 0; h < NUM_REQ; h++) begin
               if (bus.s_cmd_ready[h] && req_asking[h]) begin
                  req_asking[h]  = 1'b0;
                  req_seq[h]     = req_idx[h];
                  req_total[h]   = beatsOf(req_len[h][req_idx[h]]);
                  req_beat[h]    = 0;
                  req_in_data[h] = (req_total[h] > 0);
                  req_idx[h]++;
               end
            end
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_in_data[i] && acc[i]) begin
            req_beat[i]++;
            if (req_beat[i] >= req_total[i]) req_in_data[i] = 1'b0;
         end
      end
      if (bus.m_cmd_valid && !bus.m_cmd_ready) cmd_wait++;
      else cmd_wait = 0;

      @(posedge hbm_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!req_asking[i] && !req_in_data[i] && req_idx[i] < req_cnt[i] &&
             $urandom_range(99) < start_prob)
            req_asking[i] = 1'b1;
         bus.s_cmd_valid[i] = req_asking[i];
         if (req_asking[i]) begin
            bus.s_cmd_address[64*i +: 64] = req_addr[i][req_idx[i]];
            bus.s_cmd_length[32*i +: 32]  = req_len[i][req_idx[i]];
         end else begin
            bus.s_cmd_address[64*i +: 64] = {$urandom, $urandom};
            bus.s_cmd_length[32*i +: 32]  = $urandom;
         end
         if (req_in_data[i]) begin
            if (!(bus.s_data_valid[i] && !acc[i]))
               bus.s_data_valid[i] = ($urandom_range(99) < data_prob);
            bus.s_data_data[512*i +: 512] = beatData(i, req_seq[i], req_beat[i]);
         end else begin
            bus.s_data_valid[i]           = 1'b0;
            bus.s_data_data[512*i +: 512] = {16{$urandom}};
         end
      end
      case (cmd_rdy_mode)
         0:       bus.m_cmd_ready = 1'b1;
         1:       bus.m_cmd_ready = $urandom_range(1);
         default: bus.m_cmd_ready = (cmd_wait >= 5);
      endcase
      case (data_rdy_mode)
         0:       bus.m_data_ready = 1'b1;
         1:       bus.m_data_ready = $urandom_range(1);
         default: bus.m_data_ready = cyc[0];
      endcase
      cyc++;
   endtask

   task automatic runUntilDone(input string name, input int budget);
      int n = 0;
      while (!allDone() && n < budget) begin
         applyStimulus();
         n++;
      end
      if (!allDone())
         failNote({name, "_timeout"}, $sformatf("not drained after %0d cycles, cmds left=%0d beats left=%0d",
                  budget, exp_cmd_q.size(), exp_beat_q.size()));
      @(negedge hbm_clk);
      checkOutput({name, "_busy_idle"}, 512'(busy), 512'(0));
   endtask

   task automatic applyReset();
      hbm_areset = 1'b1;
      mon_en     = 1'b0;
      idleInputs();
      exp_cmd_q.delete();
      exp_beat_q.delete();
      clearReqs();
      model_last = NUM_REQ - 1;
      repeat (2) @(posedge hbm_clk);
      @(negedge hbm_clk);
      hbm_areset = 1'b0;
      mon_en     = 1'b1;
      @(posedge hbm_clk);
      #1;
   endtask

   task automatic checkQuiet(input string pfx);
      checkOutput({pfx, "_busy"},         512'(busy),             512'(0));
      checkOutput({pfx, "_grant_id"},     512'(grant_id),         512'(0));
      checkOutput({pfx, "_m_cmd_valid"},  512'(bus.m_cmd_valid),  512'(0));
      checkOutput({pfx, "_m_data_valid"}, 512'(bus.m_data_valid), 512'(0));
      checkOutput({pfx, "_m_data_last"},  512'(bus.m_data_last),  512'(0));
      checkOutput({pfx, "_s_cmd_ready"},  512'(bus.s_cmd_ready),  512'(0));
      checkOutput({pfx, "_s_data_ready"}, 512'(bus.s_data_ready), 512'(0));
   endtask

   // Monitor: compares every DMA-side command and beat against the scoreboard queues.
   initial begin
      cmd_exp_t  ce;
      beat_exp_t be;
      forever begin
         @(negedge hbm_clk);
         if (mon_en && !hbm_areset) begin
            if (bus.m_cmd_valid) begin
               if (exp_cmd_q.size() == 0) begin
                  failNote("m_cmd_unexpected", $sformatf("m_cmd_valid with addr=%0h len=%0d and nothing expected",
                           bus.m_cmd_address, bus.m_cmd_length));
               end else if (bus.m_cmd_ready) begin
                  ce = exp_cmd_q.pop_front();
                  checkOutput("m_cmd_address", 512'(bus.m_cmd_address), 512'(ce.addr));
                  checkOutput("m_cmd_length",  512'(bus.m_cmd_length),  512'(ce.len));
                  checkOutput("grant_id",      512'(grant_id),          512'(ce.id));
                  act_grant_q.push_back(grant_id);
               end else begin
                  ce = exp_cmd_q[0];
                  checkOutput("m_cmd_address_hold", 512'(bus.m_cmd_address), 512'(ce.addr));
                  checkOutput("m_cmd_length_hold",  512'(bus.m_cmd_length),  512'(ce.len));
               end
            end
            if (bus.m_data_valid) begin
               if (exp_beat_q.size() == 0) begin
                  failNote("m_data_unexpected", "m_data_valid with no beat expected");
               end else begin
                  be = exp_beat_q[0];
                  checkOutput("m_data_last", 512'(bus.m_data_last), 512'(be.last));
                  if (bus.m_data_ready) begin
                     void'(exp_beat_q.pop_front());
                     checkOutput("m_data_data", bus.m_data_data, be.data);
                     checkOutput("m_data_keep", 512'(bus.m_data_keep), 512'({64{1'b1}}));
                  end
               end
            end else if (bus.m_data_last) begin
               failNote("m_data_last_no_valid", "m_data_last high while m_data_valid low");
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int order [5];
      int n;
      order = '{0, 1, 2, 3, 0};
      cyc = 0;
      hbm_areset = 1'b1;
      mon_en = 1'b0;
      idleInputs();
      clearReqs();
      setModes(0, 0, 100, 100);
      model_last = NUM_REQ - 1;
      repeat (3) @(posedge hbm_clk);
      @(negedge hbm_clk);
      checkQuiet("reset");
      hbm_areset = 1'b0;
      mon_en = 1'b1;
      @(posedge hbm_clk);
      #1;

      $display("[TB] all four requesters, 64 B each, round-robin order");
      act_grant_q.delete();
      loadCmd(0, 64'h0000_0000_0000_0100, 32'd64);
      loadCmd(0, 64'h0000_0000_0000_0140, 32'd64);
      loadCmd(1, 64'h0000_0000_0001_0100, 32'd64);
      loadCmd(2, 64'h0000_0000_0002_0100, 32'd64);
      loadCmd(3, 64'h0000_0000_0003_0100, 32'd64);
      runUntilDone("rr_all4", 300);
      checkOutput("rr_grant_count", 512'(act_grant_q.size()), 512'(5));
      for (int k = 0; k < 5 && k < act_grant_q.size(); k++)
         checkOutput($sformatf("rr_order_%0d", k), 512'(act_grant_q[k]), 512'(order[k]));

      $display("[TB] single request on requester 1, 256 B");
      clearReqs();
      act_grant_q.delete();
      loadCmd(1, 64'h0000_0000_0000_1000, 32'd256);
      runUntilDone("single_req", 100);
      checkOutput("single_req_grant", 512'(act_grant_q.size() > 0 ? act_grant_q[0] : 2'd0), 512'(1));

      $display("[TB] backpressure: cmd stall then toggling data ready");
      clearReqs();
      setModes(2, 2, 100, 100);
      loadCmd(0, 64'hDEAD_BEEF_0000_0000, 32'd300);
      loadCmd(2, 64'h0123_4567_89AB_CDE0, 32'd200);
      runUntilDone("backpressure", 400);

      $display("[TB] odd lengths: 100, 0, 1, 65");
      clearReqs();
      setModes(1, 1, 60, 80);
      loadCmd(3, 64'h0000_0000_0000_3000, 32'd100);
      loadCmd(1, 64'h0000_0000_0000_1100, 32'd0);
      loadCmd(0, 64'h0000_0000_0000_0400, 32'd1);
      loadCmd(2, 64'h0000_0000_0000_2200, 32'd65);
      runUntilDone("odd_len", 400);

      $display("[TB] randomized rounds");
      for (int r = 0; r < 4; r++) begin
         clearReqs();
         setModes($urandom_range(2), $urandom_range(2), $urandom_range(20, 100), $urandom_range(30, 100));
         for (int i = 0; i < NUM_REQ; i++) begin
            n = $urandom_range(1, 4);
            for (int c = 0; c < n; c++)
               loadCmd(i, {$urandom, $urandom}, ($urandom_range(7) == 0) ? 32'd0 : 32'($urandom_range(1, 700)));
         end
         runUntilDone($sformatf("random_%0d", r), 4000);
      end

      $display("[TB] reset during beat 2 of 4");
      clearReqs();
      setModes(0, 0, 100, 100);
      loadCmd(2, 64'h0000_0000_0000_2000, 32'd256);
      n = 0;
      while (req_beat[2] < 1 && n < 50) begin
         applyStimulus();
         n++;
      end
      if (req_beat[2] < 1) failNote("reset_setup_timeout", "first beat never accepted");
      hbm_areset = 1'b1;
      mon_en = 1'b0;
      #2;
      checkQuiet("rst_mid");
      applyReset();
      act_grant_q.delete();
      loadCmd(1, 64'h0000_0000_0000_5100, 32'd64);
      loadCmd(3, 64'h0000_0000_0000_5300, 32'd64);
      runUntilDone("post_reset", 100);
      checkOutput("post_reset_first_grant", 512'(act_grant_q.size() > 0 ? act_grant_q[0] : 2'd3), 512'(1));

`ifdef HBM_DMA_WR_ARB_STATS_EN
      $display("[TB] statistics: three 128 B commands");
      applyReset();
      loadCmd(0, 64'h0000_0000_0000_7000, 32'd128);
      loadCmd(1, 64'h0000_0000_0000_7100, 32'd128);
      loadCmd(2, 64'h0000_0000_0000_7200, 32'd128);
      runUntilDone("stats", 200);
      checkOutput("stat_cmd_cnt",  512'(stat_cmd_cnt),  512'(3));
      checkOutput("stat_beat_cnt", 512'(stat_beat_cnt), 512'(3 * beatsOf(32'd128)));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
